// File: rtl/flip_pkg.sv
// flip_pkg: shared types and helpers for the flip lane event monitor
package flip_pkg;

    localparam int EVT_LANE_W = 16;

    typedef enum logic {EMPTY, FULL} slot_state_t;

    typedef struct packed {
        logic [EVT_LANE_W-1:0] lane;
        logic                  level;
    } flip_evt_t;

    function automatic integer lane_w(integer w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << w) - 33'd1;
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/flip_lowest_set.sv
// flip_lowest_set: priority encoder returning the lowest set bit of a mask
module flip_lowest_set #(
    parameter int WIDTH  = 2,
    parameter int LANE_W = 1
) (
    input  logic [WIDTH-1:0]  mask,
    output logic              found,
    output logic [LANE_W-1:0] index
);

    // scan from the top so the lowest set bit wins
    always_comb begin
        found = |mask;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (mask[i]) index = LANE_W'(i);
    end

endmodule

// File: rtl/flip_event_monitor.sv
// flip_event_monitor: turns lane level changes into a stream of (lane, level) events
module flip_event_monitor import flip_pkg::*; #(
    parameter int  WIDTH  = 2,
    parameter int  CNT_W  = 8,
    localparam int LANE_W = lane_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WIDTH-1:0]  lanes,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [LANE_W-1:0] evt_lane,
    output logic              evt_level,
    output logic [CNT_W-1:0]  evt_count,
    output logic [CNT_W-1:0]  drop_count
);

    slot_state_t       state_q, state_d;
    flip_evt_t         slot_q;
    logic [WIDTH-1:0]  prev_q, pend_q, lvl_q;
    logic [WIDTH-1:0]  chg, clr, pend_d, drop_mask;
    logic              primed_q, found, hs, load;
    logic [LANE_W-1:0] idx;

    flip_lowest_set #(.WIDTH(WIDTH), .LANE_W(LANE_W)) u_lowest (
        .mask  (pend_q),
        .found (found),
        .index (idx)
    );

    // change detection, slot unload/reload decisions and pending-mask update
    always_comb begin
        chg       = (lanes ^ prev_q) & {WIDTH{enable & primed_q}};
        hs        = (state_q == FULL) & evt_ready;
        load      = found & ((state_q == EMPTY) | hs);
        clr       = load ? (WIDTH'(1) << idx) : '0;
        drop_mask = chg & pend_q & ~clr;
        pend_d    = (pend_q & ~clr) | chg;
        state_d   = load ? FULL : (hs ? EMPTY : state_q);
    end

    // slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // lane sampling, pending bookkeeping, event slot and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            pend_q     <= '0;
            lvl_q      <= '0;
            slot_q     <= '0;
            evt_count  <= '0;
            drop_count <= '0;
        end else begin
            prev_q     <= lanes;
            primed_q   <= 1'b1;
            pend_q     <= pend_d;
            lvl_q      <= (lvl_q & ~chg) | (lanes & chg);
            if (load) slot_q <= '{lane: EVT_LANE_W'(idx), level: lvl_q[idx]};
            if (hs) evt_count <= CNT_W'(sat_add(32'(evt_count), 32'd1, CNT_W));
            drop_count <= CNT_W'(sat_add(32'(drop_count), 32'($countones(drop_mask)), CNT_W));
        end
    end

    assign evt_valid = (state_q == FULL);
    assign evt_lane  = LANE_W'(slot_q.lane);
    assign evt_level = slot_q.level;

endmodule
